// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: funct3 access sizes, FSM states,
// and the size-dependent alignment / byte-enable / store-data helpers.
package mem_stage_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_cls_t;

  // Stores only know SB/SH/SW; any other code (including LBU/LHU) is a word.
  function automatic size_cls_t size_cls(input logic [2:0] sz, input logic st);
    size_cls = SZ_WORD;
    if (st) begin
      case (sz)
        SB:      size_cls = SZ_BYTE;
        SH:      size_cls = SZ_HALF;
        default: size_cls = SZ_WORD;
      endcase
    end else begin
      case (sz)
        LB, LBU: size_cls = SZ_BYTE;
        LH, LHU: size_cls = SZ_HALF;
        default: size_cls = SZ_WORD;
      endcase
    end
  endfunction

  function automatic logic aligned(input size_cls_t c, input logic [1:0] a);
    case (c)
      SZ_BYTE: aligned = 1'b1;
      SZ_HALF: aligned = ~a[0];
      default: aligned = (a == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input size_cls_t c, input logic [1:0] a,
                                         input logic st);
    byte_en = 4'b1111;
    if (st) begin
      case (c)
        SZ_BYTE: byte_en = 4'b0001 << a;
        SZ_HALF: byte_en = 4'b0011 << a;
        default: byte_en = 4'b1111;
      endcase
    end
  endfunction

  function automatic logic [31:0] store_data(input size_cls_t c, input logic [31:0] wd);
    case (c)
      SZ_BYTE: store_data = {4{wd[7:0]}};
      SZ_HALF: store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Picks the addressed byte/halfword lane out of a read word and sign- or
// zero-extends it according to the funct3 load size.
module load_extend
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  size_ctl,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (size_ctl)
      LB:      data = {{24{byte_lane[7]}}, byte_lane};
      LH:      data = {{16{half_lane[15]}}, half_lane};
      LBU:     data = {24'd0, byte_lane};
      LHU:     data = {16'd0, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues one data-bus access per load/store, stalls
// execute until ack (or watchdog abort), and registers the writeback bundle.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic [31:0] pc_plus_4,
  input  logic [4:0]  dr_num,
  input  logic [1:0]  result_src,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  size_ctl,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_pc_plus_4,
  output logic [4:0]  wb_dr_num,
  output logic [1:0]  wb_result_src,
  output logic        wb_reg_write,
  output logic [31:0] fwd_data,
  output logic        bus_err,
  output logic        misalign_err
);

  localparam int WD_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_WAIT - 1);

  state_t          state, state_nx;
  logic [WD_W-1:0] wd_cnt;

  // Bus request captured at issue so it stays stable for the whole access.
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_we;
  logic [1:0]  req_lane;
  logic [2:0]  req_size;

  logic        is_mem, is_aligned;
  size_cls_t   cls;
  logic        start, capture, abort, misalign;
  logic [31:0] ext_data;

  assign is_mem     = mem_read | mem_write;
  assign cls        = size_cls(size_ctl, mem_write);
  assign is_aligned = aligned(cls, alu_result[1:0]);
  assign fwd_data   = alu_result;

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    start    = 1'b0;
    capture  = 1'b0;
    abort    = 1'b0;
    misalign = 1'b0;
    case (state)
      S_IDLE: begin
        if (!is_mem) begin
          capture = 1'b1;
        end else if (is_aligned) begin
          start    = 1'b1;
          stall    = 1'b1;
          state_nx = S_BUSY;
        end else begin
          misalign = 1'b1;
        end
      end
      S_BUSY: begin
        // Ack wins over a watchdog expiry in the same cycle.
        if (dmem_ack) begin
          capture  = 1'b1;
          state_nx = S_IDLE;
        end else if (wd_cnt == WD_LAST) begin
          abort    = 1'b1;
          state_nx = S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      wd_cnt <= '0;
    end else begin
      state <= state_nx;
      if (start || state_nx == S_IDLE) wd_cnt <= '0;
      else                             wd_cnt <= wd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_addr  <= '0;
      req_wdata <= '0;
      req_be    <= '0;
      req_we    <= 1'b0;
      req_lane  <= '0;
      req_size  <= '0;
    end else if (start) begin
      req_addr  <= {alu_result[31:2], 2'b00};
      req_wdata <= store_data(cls, write_data);
      req_be    <= byte_en(cls, alu_result[1:0], mem_write);
      req_we    <= mem_write;
      req_lane  <= alu_result[1:0];
      req_size  <= size_ctl;
    end
  end

  assign dmem_req   = (state == S_BUSY);
  assign dmem_we    = req_we;
  assign dmem_addr  = req_addr;
  assign dmem_be    = req_be;
  assign dmem_wdata = req_wdata;

  load_extend u_load_extend (
    .rdata    (dmem_rdata),
    .addr     (req_lane),
    .size_ctl (req_size),
    .data     (ext_data)
  );

  // Anything that is not a capture (stall, abort, misalign) writes a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_alu_result <= '0;
      wb_read_data  <= '0;
      wb_pc_plus_4  <= '0;
      wb_dr_num     <= '0;
      wb_result_src <= '0;
      wb_reg_write  <= 1'b0;
      bus_err       <= 1'b0;
      misalign_err  <= 1'b0;
    end else begin
      bus_err      <= abort;
      misalign_err <= misalign;
      if (capture) begin
        wb_alu_result <= alu_result;
        wb_pc_plus_4  <= pc_plus_4;
        wb_dr_num     <= dr_num;
        wb_result_src <= result_src;
        wb_reg_write  <= reg_write;
        wb_read_data  <= (state == S_BUSY && !req_we) ? ext_data : 32'd0;
      end else begin
        wb_reg_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table of single accesses plus
// hand sequences for reset, slow ack, watchdog abort and reset-in-BUSY.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_result, write_data, pc_plus_4;
  logic [4:0]  dr_num;
  logic [1:0]  result_src;
  logic        reg_write, mem_read, mem_write;
  logic [2:0]  size_ctl;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] wb_alu_result, wb_read_data, wb_pc_plus_4;
  logic [4:0]  wb_dr_num;
  logic [1:0]  wb_result_src;
  logic        wb_reg_write;
  logic [31:0] fwd_data;
  logic        bus_err, misalign_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .alu_result(alu_result), .write_data(write_data), .pc_plus_4(pc_plus_4),
    .dr_num(dr_num), .result_src(result_src), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .size_ctl(size_ctl),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data),
    .wb_pc_plus_4(wb_pc_plus_4), .wb_dr_num(wb_dr_num),
    .wb_result_src(wb_result_src), .wb_reg_write(wb_reg_write),
    .fwd_data(fwd_data), .bus_err(bus_err), .misalign_err(misalign_err)
  );

  typedef struct {
    string       name;
    logic [31:0] alu;
    logic [31:0] wd;
    logic        mr, mw, rw;
    logic [2:0]  sz;
    logic [31:0] rdata;
    logic        mem;      // access reaches the bus
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        rw_exp;
    logic        mis;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] wd, input logic mr,
                       input logic mw, input logic rw, input logic [2:0] sz);
    alu_result = alu; write_data = wd; pc_plus_4 = alu + 32'd4;
    dr_num = 5'd7; result_src = 2'b01;
    reg_write = rw; mem_read = mr; mem_write = mw; size_ctl = sz;
  endtask

  task automatic drive_nop();
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive(v.alu, v.wd, v.mr, v.mw, v.rw, v.sz);
    #1;
    chk({v.name, " fwd"}, fwd_data, v.alu);
    chk({v.name, " req idle"}, {31'd0, dmem_req}, 32'd0);
    if (!v.mem) begin
      chk({v.name, " stall"}, {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
    end else begin
      chk({v.name, " stall issue"}, {31'd0, stall}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk({v.name, " req busy"}, {31'd0, dmem_req}, 32'd1);
      chk({v.name, " addr"}, dmem_addr, {v.alu[31:2], 2'b00});
      chk({v.name, " we"}, {31'd0, dmem_we}, {31'd0, v.mw});
      chk({v.name, " be"}, {28'd0, dmem_be}, {28'd0, v.be});
      if (v.mw) chk({v.name, " wdata"}, dmem_wdata, v.wdata);
      dmem_ack = 1'b1; dmem_rdata = v.rdata;
      #1;
      chk({v.name, " stall ack"}, {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      chk({v.name, " req after ack"}, {31'd0, dmem_req}, 32'd0);
      chk({v.name, " wb_read_data"}, wb_read_data, v.rd);
    end
    chk({v.name, " wb_reg_write"}, {31'd0, wb_reg_write}, {31'd0, v.rw_exp});
    chk({v.name, " misalign_err"}, {31'd0, misalign_err}, {31'd0, v.mis});
    if (v.rw_exp) begin
      chk({v.name, " wb_alu"}, wb_alu_result, v.alu);
      chk({v.name, " wb_pc4"}, wb_pc_plus_4, v.alu + 32'd4);
    end
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"alu",    32'h1234, 32'h0,        0,0,1, 3'b000, 32'h0,        0, 4'h0, 32'h0,        32'h0,        1, 0});
    vecs.push_back('{"lw",     32'h100,  32'h0,        1,0,1, 3'b010, 32'hDEADBEEF, 1, 4'hF, 32'h0,        32'hDEADBEEF, 1, 0});
    vecs.push_back('{"lb",     32'h103,  32'h0,        1,0,1, 3'b000, 32'h80FFFFFF, 1, 4'hF, 32'h0,        32'hFFFFFF80, 1, 0});
    vecs.push_back('{"lbu",    32'h103,  32'h0,        1,0,1, 3'b100, 32'h80FFFFFF, 1, 4'hF, 32'h0,        32'h00000080, 1, 0});
    vecs.push_back('{"lb+",    32'h101,  32'h0,        1,0,1, 3'b000, 32'h00007F00, 1, 4'hF, 32'h0,        32'h0000007F, 1, 0});
    vecs.push_back('{"lh",     32'h102,  32'h0,        1,0,1, 3'b001, 32'h80011234, 1, 4'hF, 32'h0,        32'hFFFF8001, 1, 0});
    vecs.push_back('{"lhu",    32'h102,  32'h0,        1,0,1, 3'b101, 32'h80011234, 1, 4'hF, 32'h0,        32'h00008001, 1, 0});
    vecs.push_back('{"lh0",    32'h100,  32'h0,        1,0,1, 3'b001, 32'h80011234, 1, 4'hF, 32'h0,        32'h00001234, 1, 0});
    vecs.push_back('{"lundef", 32'h104,  32'h0,        1,0,1, 3'b011, 32'h11223344, 1, 4'hF, 32'h0,        32'h11223344, 1, 0});
    vecs.push_back('{"sh",     32'h202,  32'hAAAA5555, 0,1,0, 3'b001, 32'h12345678, 1, 4'hC, 32'h55555555, 32'h0,        0, 0});
    vecs.push_back('{"sb",     32'h301,  32'h123456AB, 0,1,0, 3'b000, 32'h12345678, 1, 4'h2, 32'hABABABAB, 32'h0,        0, 0});
    vecs.push_back('{"sw",     32'h400,  32'hCAFEF00D, 0,1,1, 3'b010, 32'h12345678, 1, 4'hF, 32'hCAFEF00D, 32'h0,        1, 0});
    vecs.push_back('{"lw_mis", 32'h101,  32'h0,        1,0,1, 3'b010, 32'h0,        0, 4'h0, 32'h0,        32'h0,        0, 1});
    vecs.push_back('{"lh_mis", 32'h103,  32'h0,        1,0,1, 3'b001, 32'h0,        0, 4'h0, 32'h0,        32'h0,        0, 1});
    vecs.push_back('{"sw_mis", 32'h402,  32'h1,        0,1,0, 3'b010, 32'h0,        0, 4'h0, 32'h0,        32'h0,        0, 1});
    vecs.push_back('{"alu2",   32'h5A5A, 32'h0,        0,0,1, 3'b010, 32'h0,        0, 4'h0, 32'h0,        32'h0,        1, 0});

    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    drive_nop();
    repeat (3) @(posedge clk);
    #1;
    chk("rst wb_alu", wb_alu_result, 32'h0);
    chk("rst wb_rd", wb_read_data, 32'h0);
    chk("rst wb_pc4", wb_pc_plus_4, 32'h0);
    chk("rst wb_rw", {31'd0, wb_reg_write}, 32'd0);
    chk("rst req", {31'd0, dmem_req}, 32'd0);
    chk("rst bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst mis", {31'd0, misalign_err}, 32'd0);
    @(negedge clk); reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Slow ack: two waiting BUSY cycles, address held, one-shot writeback.
    @(negedge clk); drive(32'h600, 32'h0, 1, 0, 1, 3'b010);
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("slow req", {31'd0, dmem_req}, 32'd1);
      chk("slow stall", {31'd0, stall}, 32'd1);
      chk("slow addr", dmem_addr, 32'h600);
      @(posedge clk); #1;
      chk("slow wb_rw bubble", {31'd0, wb_reg_write}, 32'd0);
    end
    @(negedge clk); dmem_ack = 1'b1; dmem_rdata = 32'h0BADF00D;
    @(posedge clk); #1; dmem_ack = 1'b0;
    chk("slow wb_rd", wb_read_data, 32'h0BADF00D);
    chk("slow wb_rw", {31'd0, wb_reg_write}, 32'd1);
    @(negedge clk); drive_nop();
    @(posedge clk); #1;
    chk("slow no dup", {31'd0, wb_reg_write}, 32'd0);

    // Watchdog: MAX_WAIT=4, no ack; fourth BUSY cycle aborts.
    @(negedge clk); drive(32'h500, 32'h0, 1, 0, 1, 3'b010);
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("wd req", {31'd0, dmem_req}, 32'd1);
      chk("wd stall", {31'd0, stall}, (c == 3) ? 32'd0 : 32'd1);
      if (c == 3) drive_nop();
      @(posedge clk); #1;
      chk("wd bus_err", {31'd0, bus_err}, (c == 3) ? 32'd1 : 32'd0);
    end
    chk("wd idle req", {31'd0, dmem_req}, 32'd0);
    chk("wd wb_rw", {31'd0, wb_reg_write}, 32'd0);
    @(posedge clk); #1;
    chk("wd pulse end", {31'd0, bus_err}, 32'd0);

    // Ack in the abort cycle completes normally.
    @(negedge clk); drive(32'h504, 32'h0, 1, 0, 1, 3'b010);
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk); dmem_ack = 1'b1; dmem_rdata = 32'h13572468;
    #1; chk("late ack stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1; dmem_ack = 1'b0;
    chk("late ack bus_err", {31'd0, bus_err}, 32'd0);
    chk("late ack wb_rd", wb_read_data, 32'h13572468);
    chk("late ack wb_rw", {31'd0, wb_reg_write}, 32'd1);
    @(negedge clk); drive_nop();

    // Reset in BUSY with a coincident ack abandons the access silently.
    @(negedge clk); drive(32'h700, 32'h0, 1, 0, 1, 3'b010);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rbusy req", {31'd0, dmem_req}, 32'd1);
    reset = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("rbusy req after", {31'd0, dmem_req}, 32'd0);
    chk("rbusy bus_err", {31'd0, bus_err}, 32'd0);
    chk("rbusy wb_rw", {31'd0, wb_reg_write}, 32'd0);
    chk("rbusy wb_rd", wb_read_data, 32'h0);
    @(negedge clk); reset = 1'b0; drive_nop();
    repeat (5) begin
      @(posedge clk); #1;
      chk("rbusy quiet bus_err", {31'd0, bus_err}, 32'd0);
      chk("rbusy quiet req", {31'd0, dmem_req}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
